player_car_ctrl: RTL and testbench

- Motion and state controller for the player car sprite.
- Samples the four direction buttons once per video frame, steps the car position, and clamps it to the road area.
- Drives the car_yellowX/car_yellowY position inputs of the player car sprite block, plus a visibility enable for the pixel compositor.
- Runs an IDLE/RUN/CRASH state machine. A crash freezes the car, blinks it for a fixed number of frames, then respawns it.

---
 rtl/player_car_ctrl.sv | 178 +++++++++++++++++
 tb/tb_player_car_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_car_ctrl.sv
// Player car motion and IDLE/RUN/CRASH controller.
// Steps once per video frame, clamps to the road, blinks and respawns on crash.
module player_car_ctrl #(
  parameter int X_INIT       = 305,
  parameter int Y_INIT       = 405,
  parameter int X_MIN        = 160,
  parameter int X_MAX        = 448,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 416,
  parameter int STEP         = 4,
  parameter int CRASH_FRAMES = 60,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_row,
  input  logic [9:0] pix_col,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       game_start,
  input  logic       collision,
  output logic [9:0] car_yellowX,
  output logic [9:0] car_yellowY,
  output logic       car_visible,
  output logic [1:0] ctrl_state,
  output logic [7:0] crash_count
);

  localparam int FW = $clog2(CRASH_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [9:0] XI  = 10'(X_INIT);
  localparam logic [9:0] YI  = 10'(Y_INIT);
  localparam logic [9:0] XMN = 10'(X_MIN);
  localparam logic [9:0] XMX = 10'(X_MAX);
  localparam logic [9:0] YMN = 10'(Y_MIN);
  localparam logic [9:0] YMX = 10'(Y_MAX);
  localparam logic [9:0] STP = 10'(STEP);

  localparam logic [FW-1:0] FLOAD = FW'(CRASH_FRAMES);
  localparam logic [BW-1:0] BLOAD = BW'(BLINK_FRAMES);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    CRASH = 2'b10
  } state_t;

  state_t        state, state_nx;
  logic          cond_q, cond_qq, tick;
  logic          hit, hit_nx;
  logic [9:0]    x, x_nx, x_mv;
  logic [9:0]    y, y_nx, y_mv;
  logic          vis, vis_nx;
  logic [7:0]    cnt, cnt_nx;
  logic [FW-1:0] fcnt, fcnt_nx;
  logic [BW-1:0] bcnt, bcnt_nx;

  logic frame_cond;
  logic mv_l, mv_r, mv_u, mv_d;

  assign frame_cond = (pix_row == 10'd480) && (pix_col == 10'd0);

  assign mv_l = btn_left  & ~btn_right;
  assign mv_r = btn_right & ~btn_left;
  assign mv_u = btn_up    & ~btn_down;
  assign mv_d = btn_down  & ~btn_up;

  // Clamp before the step so unsigned position never wraps.
  always_comb begin
    x_mv = x;
    unique case (1'b1)
      mv_l:    x_mv = (x < XMN + STP) ? XMN : x - STP;
      mv_r:    x_mv = (x > XMX - STP) ? XMX : x + STP;
      default: x_mv = x;
    endcase
  end

  always_comb begin
    y_mv = y;
    unique case (1'b1)
      mv_u:    y_mv = (y < YMN + STP) ? YMN : y - STP;
      mv_d:    y_mv = (y > YMX - STP) ? YMX : y + STP;
      default: y_mv = y;
    endcase
  end

  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    vis_nx   = vis;
    cnt_nx   = cnt;
    fcnt_nx  = fcnt;
    bcnt_nx  = bcnt;
    hit_nx   = 1'b0;
    case (state)
      IDLE: begin
        x_nx   = XI;
        y_nx   = YI;
        vis_nx = 1'b1;
        if (game_start) state_nx = RUN;
      end
      RUN: begin
        // A collision on the tick cycle survives the clear.
        hit_nx = collision | (hit & ~tick);
        if (tick) begin
          if (hit) begin
            state_nx = CRASH;
            hit_nx   = 1'b0;
            vis_nx   = 1'b0;
            fcnt_nx  = FLOAD;
            bcnt_nx  = BLOAD;
            cnt_nx   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
          end else begin
            x_nx = x_mv;
            y_nx = y_mv;
          end
        end
      end
      CRASH: begin
        if (tick) begin
          fcnt_nx = fcnt - 1'b1;
          if (bcnt == BW'(1)) begin
            vis_nx  = ~vis;
            bcnt_nx = BLOAD;
          end else begin
            bcnt_nx = bcnt - 1'b1;
          end
          if (fcnt == FW'(1)) begin
            state_nx = RUN;
            x_nx     = XI;
            y_nx     = YI;
            vis_nx   = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cond_q  <= 1'b0;
      cond_qq <= 1'b0;
      tick    <= 1'b0;
      state   <= IDLE;
      hit     <= 1'b0;
      x       <= XI;
      y       <= YI;
      vis     <= 1'b1;
      cnt     <= 8'd0;
      fcnt    <= '0;
      bcnt    <= '0;
    end else begin
      cond_q  <= frame_cond;
      cond_qq <= cond_q;
      tick    <= cond_q & ~cond_qq;
      state   <= state_nx;
      hit     <= hit_nx;
      x       <= x_nx;
      y       <= y_nx;
      vis     <= vis_nx;
      cnt     <= cnt_nx;
      fcnt    <= fcnt_nx;
      bcnt    <= bcnt_nx;
    end
  end

  assign car_yellowX = x;
  assign car_yellowY = y;
  assign car_visible = vis;
  assign ctrl_state  = state;
  assign crash_count = cnt;

endmodule

// File: tb/tb_player_car_ctrl.sv
// Bench for player_car_ctrl: frame-level behavioural model checked
// every cycle, plus literal pins on key positions and counters.
module tb_player_car_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] pix_row = '0;
  logic [9:0] pix_col = '0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       game_start = 1'b0;
  logic       collision = 1'b0;
  logic [9:0] car_yellowX;
  logic [9:0] car_yellowY;
  logic       car_visible;
  logic [1:0] ctrl_state;
  logic [7:0] crash_count;

  player_car_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .pix_row     (pix_row),
    .pix_col     (pix_col),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .game_start  (game_start),
    .collision   (collision),
    .car_yellowX (car_yellowX),
    .car_yellowY (car_yellowY),
    .car_visible (car_visible),
    .ctrl_state  (ctrl_state),
    .crash_count (crash_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Frame-level model: st 0 idle, 1 run, 2 crash; k = crash frames elapsed.
  int m_x = 305, m_y = 405, m_st = 0, m_cnt = 0, m_k = 0;
  bit m_vis = 1'b1, m_hit = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("x", car_yellowX, m_x);
      chk("y", car_yellowY, m_y);
      chk("visible", car_visible, m_vis);
      chk("state", ctrl_state, m_st);
      chk("crash_count", crash_count, m_cnt);
    end
  end

  task automatic model_reset();
    m_x = 305; m_y = 405; m_st = 0; m_cnt = 0;
    m_k = 0; m_vis = 1'b1; m_hit = 1'b0;
  endtask

  task automatic model_tick();
    case (m_st)
      1: begin
        if (m_hit) begin
          m_st = 2; m_k = 0; m_vis = 1'b0;
          m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
        end else begin
          if (btn_left && !btn_right) m_x = (m_x < 164) ? 160 : m_x - 4;
          if (btn_right && !btn_left) m_x = (m_x > 444) ? 448 : m_x + 4;
          if (btn_up && !btn_down) m_y = (m_y < 4) ? 0 : m_y - 4;
          if (btn_down && !btn_up) m_y = (m_y > 412) ? 416 : m_y + 4;
        end
      end
      2: begin
        m_k++;
        if (m_k == 60) begin
          m_st = 1; m_x = 305; m_y = 405; m_vis = 1'b1;
        end else begin
          m_vis = ((m_k / 8) % 2) == 1;
        end
      end
      default: ;
    endcase
  endtask

  // One frame: frame pixel held `hold` clocks. coll: 0 none, 1 pulse in
  // first clock, 2 only on the tick clock, 3 high through the whole frame.
  task automatic frame(input int hold, input int coll, input bit st_tick);
    int pre;
    bit carry;
    pix_row = 10'd480;
    pix_col = 10'd0;
    collision = (coll == 1 || coll == 3);
    if (m_st == 1 && collision) m_hit = 1'b1;
    for (int i = 0; i < hold + 2; i++) begin
      @(negedge clk);
      if (i == hold - 1) pix_row = 10'd0;
      if (i == 0 && coll == 1) collision = 1'b0;
      if (i == 1) begin
        pre = m_st;
        model_tick();
        carry = (coll == 2 || coll == 3);
        m_hit = carry && pre == 1 && m_st == 1;
        collision = carry;
        if (st_tick) begin
          game_start = 1'b1;
          if (m_st == 0) m_st = 1;
        end
      end
    end
    collision = 1'b0;
    game_start = 1'b0;
  endtask

  task automatic start_pulse();
    game_start = 1'b1;
    if (m_st == 0) m_st = 1;
    @(negedge clk);
    game_start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_x", car_yellowX, 305);
    chk("reset_y", car_yellowY, 405);
    chk("reset_vis", car_visible, 1);
    chk("reset_state", ctrl_state, 0);
    chk("reset_count", crash_count, 0);
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    btn_right = 1'b1;
    start_pulse();
    repeat (3) frame(1, 0, 0);
    chk("pin_x317", car_yellowX, 317);
    chk("pin_run", ctrl_state, 1);
    btn_right = 1'b0;
    start_pulse();

    btn_left = 1'b1;
    repeat (45) frame(1, 0, 0);
    chk("pin_xmin", car_yellowX, 160);
    btn_left = 1'b0;
    btn_right = 1'b1;
    repeat (80) frame(1, 0, 0);
    chk("pin_xmax", car_yellowX, 448);
    btn_right = 1'b0;
    btn_down = 1'b1;
    repeat (5) frame(1, 0, 0);
    chk("pin_ymax", car_yellowY, 416);
    btn_down = 1'b0;

    btn_left = 1'b1;
    btn_right = 1'b1;
    repeat (5) frame(1, 0, 0);
    chk("pin_lr_hold", car_yellowX, 448);
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_up = 1'b1;
    repeat (3) frame(1, 0, 0);
    chk("pin_up", car_yellowY, 404);
    btn_up = 1'b0;

    frame(1, 2, 0);
    chk("pin_tick_coll_run", ctrl_state, 1);
    frame(1, 0, 0);
    chk("pin_crash_state", ctrl_state, 2);
    chk("pin_crash_cnt", crash_count, 1);
    chk("pin_crash_vis", car_visible, 0);
    for (int i = 1; i <= 59; i++) begin
      frame(1, (i <= 49) ? 3 : 0, 0);
      if (i == 8) chk("pin_blink8", car_visible, 1);
    end
    chk("pin_still_crash", ctrl_state, 2);
    chk("pin_no_recount", crash_count, 1);
    frame(1, 0, 0);
    chk("pin_respawn_x", car_yellowX, 305);
    chk("pin_respawn_y", car_yellowY, 405);
    chk("pin_respawn_vis", car_visible, 1);
    chk("pin_respawn_st", ctrl_state, 1);

    btn_right = 1'b1;
    frame(10, 0, 0);
    chk("pin_long_pixel", car_yellowX, 309);
    btn_right = 1'b0;

    frame(1, 1, 0);
    repeat (20) frame(1, 0, 0);
    chk_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_x", car_yellowX, 305);
    chk("async_y", car_yellowY, 405);
    chk("async_vis", car_visible, 1);
    chk("async_state", ctrl_state, 0);
    chk("async_count", crash_count, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;

    btn_right = 1'b1;
    frame(1, 0, 0);
    frame(1, 0, 1);
    chk("pin_start_tick_x", car_yellowX, 305);
    chk("pin_start_tick_st", ctrl_state, 1);
    frame(1, 0, 0);
    chk("pin_after_start", car_yellowX, 309);
    btn_right = 1'b0;

    for (int n = 0; n < 260; n++) begin
      frame(1, 1, 0);
      repeat (60) frame(1, 0, 0);
    end
    chk("pin_saturate", crash_count, 255);
    chk("pin_sat_state", ctrl_state, 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
